// File: rtl/apg_host_sequencer_if.sv
// Purpose: bundles the sequencer <-> pattern-generator signals (pattern load, run, readback).
// Latency: wires only, no storage.
// Backpressure: none; the generator must accept one strobe per axi_clk cycle.
interface apg_host_sequencer_if #(
    parameter int NUM_SIG = 12
);
    logic [NUM_SIG-1:0] write_channel;
    logic               write_channel_wrStrobe;
    logic               run;
    logic [31:0]        n_samples;
    logic               read_channel_rdStrobe;
    logic [NUM_SIG-1:0] read_channel;

    // Sequencer side drives the generator
    modport master (
        output write_channel,
        output write_channel_wrStrobe,
        output run,
        output n_samples,
        output read_channel_rdStrobe,
        input  read_channel
    );

    // Generator side
    modport slave (
        input  write_channel,
        input  write_channel_wrStrobe,
        input  run,
        input  n_samples,
        input  read_channel_rdStrobe,
        output read_channel
    );
endinterface

// File: rtl/apg_host_sequencer.sv
// Purpose: streams a buffered pattern into the generator, pulses run, waits, drains readback into capture RAM.
// Latency: done = 2n + 3 + (n+2)*WAVE_DIV + READ_LAT cycles after start is sampled (n = clamped count).
// Backpressure: none; start is ignored while busy and pattern writes are dropped while busy.
module apg_host_sequencer #(
    parameter int NUM_SIG  = 12,
    parameter int NUM_SAMP = 128,
    parameter int WAVE_DIV = 100,
    parameter int READ_LAT = 1,
    localparam int AW      = $clog2(NUM_SAMP)
) (
    input  logic                axi_clk,
    input  logic                axi_reset,
    input  logic                start,
    input  logic [31:0]         n_samples_cfg,
    input  logic                pat_wr_en,
    input  logic [AW-1:0]       pat_wr_addr,
    input  logic [NUM_SIG-1:0]  pat_wr_data,
    input  logic [AW-1:0]       cap_rd_addr,
    output logic [NUM_SIG-1:0]  cap_rd_data,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    apg_host_sequencer_if.master gen
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_RUN, S_WAIT, S_DRAIN, S_FLUSH, S_DONE
    } state_t;

    state_t              state;
    logic [NUM_SIG-1:0]  pat_mem [NUM_SAMP];
    logic [NUM_SIG-1:0]  cap_mem [NUM_SAMP];
    logic [31:0]         n_lat;
    logic                err_lat;
    logic [31:0]         cnt;
    logic [31:0]         n_clamp;
    logic                cfg_bad;
    logic [31:0]         wait_last;
    logic [READ_LAT-1:0] rd_pipe;
    logic [AW-1:0]       cap_idx;
    logic                cap_we;

    // Requested count clamped to the RAM depth; zero or oversize requests are flagged
    assign n_clamp   = (n_samples_cfg > 32'(NUM_SAMP)) ? 32'(NUM_SAMP) : n_samples_cfg;
    assign cfg_bad   = (n_samples_cfg == 32'd0) || (n_samples_cfg > 32'(NUM_SAMP));
    // Wave-clock capture window covers n samples plus two wave periods of slack
    assign wait_last = (n_lat + 32'd2) * 32'(WAVE_DIV) - 32'd1;
    // rd_pipe tracks each rdStrobe until its data appears on read_channel
    assign cap_we    = rd_pipe[READ_LAT-1];

    // Pattern RAM: host may only write while the sequencer is idle
    always_ff @(posedge axi_clk) begin
        if (pat_wr_en && state == S_IDLE)
            pat_mem[pat_wr_addr] <= pat_wr_data;
    end

    // Capture RAM write, one entry per returned sample
    always_ff @(posedge axi_clk) begin
        if (cap_we && !axi_reset)
            cap_mem[cap_idx] <= gen.read_channel;
    end

    // Capture RAM host read port, one-cycle latency
    always_ff @(posedge axi_clk) begin
        if (axi_reset)
            cap_rd_data <= '0;
        else
            cap_rd_data <= cap_mem[cap_rd_addr];
    end

    // Sequencer FSM; every generator-facing output is registered here
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state                      <= S_IDLE;
            n_lat                      <= '0;
            err_lat                    <= 1'b0;
            cnt                        <= '0;
            rd_pipe                    <= '0;
            cap_idx                    <= '0;
            busy                       <= 1'b0;
            done                       <= 1'b0;
            cfg_err                    <= 1'b0;
            gen.write_channel          <= '0;
            gen.write_channel_wrStrobe <= 1'b0;
            gen.run                    <= 1'b0;
            gen.n_samples              <= '0;
            gen.read_channel_rdStrobe  <= 1'b0;
        end else begin
            rd_pipe[0] <= gen.read_channel_rdStrobe;
            for (int j = 1; j < READ_LAT; j++)
                rd_pipe[j] <= rd_pipe[j-1];
            if (cap_we)
                cap_idx <= cap_idx + 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat         <= n_clamp;
                        err_lat       <= cfg_bad;
                        gen.n_samples <= n_clamp;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        if (n_clamp == 32'd0) begin
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                // First LOAD cycle fetches pat_mem[0]; strobes then run for n cycles
                S_LOAD: begin
                    if (cnt == n_lat) begin
                        gen.write_channel_wrStrobe <= 1'b0;
                        gen.write_channel          <= '0;
                        state                      <= S_GAP;
                    end else begin
                        gen.write_channel_wrStrobe <= 1'b1;
                        gen.write_channel          <= pat_mem[cnt[AW-1:0]];
                        cnt                        <= cnt + 32'd1;
                    end
                end
                S_GAP: begin
                    gen.run <= 1'b1;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    gen.run <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == wait_last) begin
                        gen.read_channel_rdStrobe <= 1'b1;
                        cnt                       <= 32'd1;
                        cap_idx                   <= '0;
                        state                     <= S_DRAIN;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                // cnt counts strobes already issued
                S_DRAIN: begin
                    if (cnt == n_lat) begin
                        gen.read_channel_rdStrobe <= 1'b0;
                        cnt                       <= 32'd1;
                        state                     <= S_FLUSH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                // Hold off done until the last sample has landed in the capture RAM
                S_FLUSH: begin
                    if (cnt == 32'(READ_LAT)) begin
                        done    <= 1'b1;
                        cfg_err <= err_lat;
                        state   <= S_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    done          <= 1'b0;
                    cfg_err       <= 1'b0;
                    busy          <= 1'b0;
                    gen.n_samples <= '0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apg_host_sequencer.sv
// Purpose: self-checking bench for apg_host_sequencer with a behavioural generator model.
// Latency: expected timing derived from the sequence rules (n strobes, gap, run, (n+2)*WAVE_DIV wait, drain, flush).
// Backpressure: not applicable; the generator model accepts every strobe.
module tb_apg_host_sequencer;
    localparam int NUM_SIG  = 12;
    localparam int NUM_SAMP = 128;
    localparam int WAVE_DIV = 100;
    localparam int READ_LAT = 1;
    localparam int AW       = 7;

    logic               axi_clk = 1'b0;
    logic               axi_reset;
    logic               start;
    logic [31:0]        n_samples_cfg;
    logic               pat_wr_en;
    logic [AW-1:0]      pat_wr_addr;
    logic [NUM_SIG-1:0] pat_wr_data;
    logic [AW-1:0]      cap_rd_addr;
    logic [NUM_SIG-1:0] cap_rd_data;
    logic               busy;
    logic               done;
    logic               cfg_err;

    apg_host_sequencer_if #(.NUM_SIG(NUM_SIG)) gen_if ();

    apg_host_sequencer #(
        .NUM_SIG(NUM_SIG), .NUM_SAMP(NUM_SAMP), .WAVE_DIV(WAVE_DIV), .READ_LAT(READ_LAT)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .start(start), .n_samples_cfg(n_samples_cfg),
        .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
        .cap_rd_addr(cap_rd_addr), .cap_rd_data(cap_rd_data), .busy(busy), .done(done),
        .cfg_err(cfg_err), .gen(gen_if)
    );

    always #5 axi_clk = ~axi_clk;

    int cyc = 0;
    always @(posedge axi_clk) cyc <= cyc + 1;

    // Reference state
    logic [NUM_SIG-1:0] pat_model [NUM_SAMP];
    logic [NUM_SIG-1:0] cap_model [NUM_SAMP];
    logic [NUM_SIG-1:0] resp      [NUM_SAMP];
    logic [NUM_SIG-1:0] wr_log    [NUM_SAMP];

    // Observations from the generator model
    int   wr_cnt = 0, wr_first = -1, wr_last = -1;
    int   run_cnt = 0, run_cyc = -1;
    int   rd_cnt = 0, rd_first = -1, rd_last = -1;
    int   done_cnt = 0, done_cyc = -1;
    logic done_err = 1'b0;

    int   nvec = 0, nerr = 0;
    int   s0 = 0;
    logic tmo = 1'b0;

    // Generator model: logs strobes, answers each rdStrobe READ_LAT(=1) cycle later
    initial begin
        logic [NUM_SIG-1:0] nxt;
        logic               have;
        gen_if.read_channel = '0;
        forever begin
            @(negedge axi_clk);
            have = 1'b0;
            nxt  = '0;
            if (gen_if.write_channel_wrStrobe === 1'b1) begin
                if (wr_cnt == 0) wr_first = cyc;
                wr_last = cyc;
                if (wr_cnt < NUM_SAMP) wr_log[wr_cnt] = gen_if.write_channel;
                wr_cnt++;
            end
            if (gen_if.run === 1'b1) begin
                run_cnt++;
                run_cyc = cyc;
            end
            if (gen_if.read_channel_rdStrobe === 1'b1) begin
                if (rd_cnt == 0) rd_first = cyc;
                rd_last = cyc;
                if (rd_cnt < NUM_SAMP) nxt = resp[rd_cnt];
                have = 1'b1;
                rd_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = cfg_err;
            end
            @(posedge axi_clk);
            #1;
            gen_if.read_channel = have ? nxt : NUM_SIG'($urandom);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int exp_n(input logic [31:0] cfg);
        return (cfg > NUM_SAMP) ? NUM_SAMP : int'(cfg);
    endfunction

    function automatic int exp_wait(input int n);
        return (n + 2) * WAVE_DIV;
    endfunction

    task automatic clear_mon();
        wr_cnt = 0; wr_first = -1; wr_last = -1;
        run_cnt = 0; run_cyc = -1;
        rd_cnt = 0; rd_first = -1; rd_last = -1;
        done_cnt = 0; done_cyc = -1; done_err = 1'b0;
    endtask

    task automatic pat_write(input int a, input logic [NUM_SIG-1:0] d);
        @(posedge axi_clk); #1;
        pat_wr_en = 1'b1; pat_wr_addr = AW'(a); pat_wr_data = d;
        @(posedge axi_clk); #1;
        pat_wr_en = 1'b0;
        pat_model[a] = d;
    endtask

    task automatic launch(input logic [31:0] cfg);
        @(posedge axi_clk); #1;
        start = 1'b1; n_samples_cfg = cfg;
        @(posedge axi_clk); #1;
        start = 1'b0;
        s0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        tmo = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge axi_clk);
            if (done_cnt > 0) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic cap_read(input int a, output logic [NUM_SIG-1:0] d);
        @(posedge axi_clk); #1;
        cap_rd_addr = AW'(a);
        @(posedge axi_clk); #1;
        d = cap_rd_data;
    endtask

    task automatic commit(input int n);
        for (int i = 0; i < n; i++) cap_model[i] = resp[i];
    endtask

    task automatic test_reset();
        axi_reset = 1'b1; start = 1'b0; n_samples_cfg = '0; pat_wr_en = 1'b0;
        pat_wr_addr = '0; pat_wr_data = '0; cap_rd_addr = '0;
        repeat (3) @(posedge axi_clk);
        #1;
        nvec++; if ({busy, done, cfg_err} !== 3'b000) begin nerr++; $display("FAIL reset_status got=%b exp=000", {busy, done, cfg_err}); end
        nvec++; if ({gen_if.write_channel_wrStrobe, gen_if.run, gen_if.read_channel_rdStrobe} !== 3'b000) begin nerr++; $display("FAIL reset_strobes got=%b exp=000", {gen_if.write_channel_wrStrobe, gen_if.run, gen_if.read_channel_rdStrobe}); end
        nvec++; if (gen_if.n_samples !== 32'd0) begin nerr++; $display("FAIL reset_n_samples got=%0d exp=0", gen_if.n_samples); end
        nvec++; if (gen_if.write_channel !== '0) begin nerr++; $display("FAIL reset_write_channel got=%0d exp=0", gen_if.write_channel); end
        axi_reset = 1'b0;
        clear_mon();
    endtask

    task automatic test_clamp();
        int bad;
        logic [NUM_SIG-1:0] d;
        for (int i = 0; i < NUM_SAMP; i++) begin
            pat_write(i, NUM_SIG'($urandom));
            resp[i] = NUM_SIG'($urandom);
        end
        clear_mon();
        launch(32'd200);
        nvec++; if (gen_if.n_samples !== 32'(exp_n(32'd200))) begin nerr++; $display("FAIL clamp_n_samples got=%0d exp=%0d", gen_if.n_samples, exp_n(32'd200)); end
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL clamp_busy got=%b exp=1", busy); end
        wait_done(20000);
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL clamp_timeout got=%b exp=0", tmo); end
        nvec++; if (wr_cnt !== NUM_SAMP) begin nerr++; $display("FAIL clamp_wr_cnt got=%0d exp=%0d", wr_cnt, NUM_SAMP); end
        nvec++; if (rd_cnt !== NUM_SAMP) begin nerr++; $display("FAIL clamp_rd_cnt got=%0d exp=%0d", rd_cnt, NUM_SAMP); end
        nvec++; if (run_cnt !== 1) begin nerr++; $display("FAIL clamp_run_cnt got=%0d exp=1", run_cnt); end
        nvec++; if (done_err !== 1'b1) begin nerr++; $display("FAIL clamp_cfg_err got=%b exp=1", done_err); end
        bad = 0;
        for (int i = 0; i < NUM_SAMP; i++) if (wr_log[i] !== pat_model[i]) bad++;
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL clamp_wr_data bad_entries=%0d exp=0", bad); end
        commit(NUM_SAMP);
        bad = 0;
        for (int i = 0; i < NUM_SAMP; i++) begin
            cap_read(i, d);
            if (d !== cap_model[i]) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL clamp_cap_data bad_entries=%0d exp=0", bad); end

        clear_mon();
        launch(32'd0);
        wait_done(10);
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL zero_timeout got=%b exp=0", tmo); end
        nvec++; if ((done_cyc - s0 <= 3) !== 1'b1) begin nerr++; $display("FAIL zero_done_delay got=%0d exp<=3", done_cyc - s0); end
        nvec++; if (wr_cnt + run_cnt + rd_cnt !== 0) begin nerr++; $display("FAIL zero_strobes got=%0d exp=0", wr_cnt + run_cnt + rd_cnt); end
        nvec++; if (done_err !== 1'b1) begin nerr++; $display("FAIL zero_cfg_err got=%b exp=1", done_err); end
        repeat (2) @(posedge axi_clk);
        #1;
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL zero_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_ramp();
        int n, bad;
        logic [NUM_SIG-1:0] d;
        logic [NUM_SIG-1:0] ramp [6];
        logic [NUM_SIG-1:0] ret  [6];
        ramp = '{12'd1, 12'd3, 12'd7, 12'd15, 12'd31, 12'd63};
        ret  = '{12'd42, 12'd85, 12'd42, 12'd85, 12'd0, 12'd127};
        n = 6;
        for (int i = 0; i < n; i++) begin
            pat_write(i, ramp[i]);
            resp[i] = ret[i];
        end
        clear_mon();
        launch(32'd6);
        wait_done(5000);
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL ramp_timeout got=%b exp=0", tmo); end
        nvec++; if (wr_cnt !== n) begin nerr++; $display("FAIL ramp_wr_cnt got=%0d exp=%0d", wr_cnt, n); end
        nvec++; if (wr_first - s0 !== 1) begin nerr++; $display("FAIL ramp_wr_first got=%0d exp=1", wr_first - s0); end
        nvec++; if (wr_last - s0 !== n) begin nerr++; $display("FAIL ramp_wr_last got=%0d exp=%0d", wr_last - s0, n); end
        bad = 0;
        for (int i = 0; i < n; i++) if (wr_log[i] !== ramp[i]) bad++;
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL ramp_wr_data bad_entries=%0d exp=0", bad); end
        nvec++; if (run_cnt !== 1) begin nerr++; $display("FAIL ramp_run_cnt got=%0d exp=1", run_cnt); end
        nvec++; if (run_cyc - s0 !== n + 2) begin nerr++; $display("FAIL ramp_run_cyc got=%0d exp=%0d", run_cyc - s0, n + 2); end
        nvec++; if (rd_cnt !== n) begin nerr++; $display("FAIL ramp_rd_cnt got=%0d exp=%0d", rd_cnt, n); end
        nvec++; if (rd_first - s0 !== n + 3 + exp_wait(n)) begin nerr++; $display("FAIL ramp_rd_first got=%0d exp=%0d", rd_first - s0, n + 3 + exp_wait(n)); end
        nvec++; if (done_cyc - s0 !== 2 * n + 3 + exp_wait(n) + READ_LAT) begin nerr++; $display("FAIL ramp_done_cyc got=%0d exp=%0d", done_cyc - s0, 2 * n + 3 + exp_wait(n) + READ_LAT); end
        nvec++; if (done_err !== 1'b0) begin nerr++; $display("FAIL ramp_cfg_err got=%b exp=0", done_err); end
        commit(n);
        for (int i = 0; i < n + 4; i++) begin
            cap_read(i, d);
            nvec++; if (d !== cap_model[i]) begin nerr++; $display("FAIL ramp_cap[%0d] got=%0d exp=%0d", i, d, cap_model[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n, bad;
        logic [NUM_SIG-1:0] d;
        n = 6;
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            launch(32'd6);
            wait_done(5000);
            nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL b2b_timeout run=%0d got=%b exp=0", k, tmo); end
            nvec++; if (wr_first - s0 !== 1 || wr_cnt !== n) begin nerr++; $display("FAIL b2b_wr run=%0d first=%0d cnt=%0d exp=1,%0d", k, wr_first - s0, wr_cnt, n); end
            nvec++; if (rd_first - s0 !== n + 3 + exp_wait(n) || rd_cnt !== n) begin nerr++; $display("FAIL b2b_rd run=%0d first=%0d cnt=%0d exp=%0d,%0d", k, rd_first - s0, rd_cnt, n + 3 + exp_wait(n), n); end
            nvec++; if (done_cyc - s0 !== 2 * n + 3 + exp_wait(n) + READ_LAT) begin nerr++; $display("FAIL b2b_done run=%0d got=%0d exp=%0d", k, done_cyc - s0, 2 * n + 3 + exp_wait(n) + READ_LAT); end
        end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            cap_read(i, d);
            if (d !== cap_model[i]) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL b2b_cap bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_random();
        int n, bad;
        logic [NUM_SIG-1:0] d;
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                pat_write(i, NUM_SIG'($urandom));
                resp[i] = NUM_SIG'($urandom);
            end
            clear_mon();
            launch(32'(n));
            wait_done(5000);
            nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL rand_timeout n=%0d got=%b exp=0", n, tmo); end
            bad = 0;
            for (int i = 0; i < n; i++) if (wr_log[i] !== pat_model[i]) bad++;
            nvec++; if (wr_cnt !== n || bad !== 0) begin nerr++; $display("FAIL rand_wr n=%0d cnt=%0d bad=%0d exp=%0d,0", n, wr_cnt, bad, n); end
            nvec++; if (rd_cnt !== n || rd_first - s0 !== n + 3 + exp_wait(n)) begin nerr++; $display("FAIL rand_rd n=%0d cnt=%0d first=%0d exp=%0d,%0d", n, rd_cnt, rd_first - s0, n, n + 3 + exp_wait(n)); end
            nvec++; if (done_cyc - s0 !== 2 * n + 3 + exp_wait(n) + READ_LAT || done_err !== 1'b0) begin nerr++; $display("FAIL rand_done n=%0d cyc=%0d err=%b exp=%0d,0", n, done_cyc - s0, done_err, 2 * n + 3 + exp_wait(n) + READ_LAT); end
            commit(n);
            bad = 0;
            for (int i = 0; i < n + 2; i++) begin
                cap_read(i, d);
                if (d !== cap_model[i]) bad++;
            end
            nvec++; if (bad !== 0) begin nerr++; $display("FAIL rand_cap n=%0d bad_entries=%0d exp=0", n, bad); end
        end
    endtask

    task automatic test_busy_ignore();
        int n, bad, wr_after;
        logic [NUM_SIG-1:0] d;
        n = 20;
        for (int i = 0; i < n; i++) begin
            pat_write(i, NUM_SIG'($urandom));
            resp[i] = NUM_SIG'($urandom);
        end
        clear_mon();
        launch(32'(n));
        repeat (5) @(posedge axi_clk);
        #1;
        start = 1'b1; pat_wr_en = 1'b1; pat_wr_addr = AW'(15); pat_wr_data = ~pat_model[15];
        @(posedge axi_clk); #1;
        start = 1'b0; pat_wr_en = 1'b0;
        repeat (40) @(posedge axi_clk);
        #1;
        start = 1'b1; pat_wr_en = 1'b1; pat_wr_addr = AW'(2); pat_wr_data = ~pat_model[2];
        @(posedge axi_clk); #1;
        start = 1'b0; pat_wr_en = 1'b0;
        wait_done(6000);
        repeat (30) @(posedge axi_clk);
        #1;
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL busy_timeout got=%b exp=0", tmo); end
        nvec++; if (done_cnt !== 1) begin nerr++; $display("FAIL busy_done_cnt got=%0d exp=1", done_cnt); end
        nvec++; if (wr_cnt !== n || run_cnt !== 1 || rd_cnt !== n) begin nerr++; $display("FAIL busy_counts wr=%0d run=%0d rd=%0d exp=%0d,1,%0d", wr_cnt, run_cnt, rd_cnt, n, n); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL busy_idle_after got=%b exp=0", busy); end
        bad = 0;
        for (int i = 0; i < n; i++) if (wr_log[i] !== pat_model[i]) bad++;
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL busy_wr_data bad_entries=%0d exp=0", bad); end
        commit(n);
        clear_mon();
        launch(32'(n));
        wait_done(6000);
        wr_after = wr_cnt;
        bad = 0;
        for (int i = 0; i < n; i++) if (wr_log[i] !== pat_model[i]) bad++;
        nvec++; if (tmo !== 1'b0 || wr_after !== n || bad !== 0) begin nerr++; $display("FAIL busy_pat_ram tmo=%b cnt=%0d bad=%0d exp=0,%0d,0", tmo, wr_after, bad, n); end
        bad = 0;
        for (int i = 0; i < n; i++) begin
            cap_read(i, d);
            if (d !== cap_model[i]) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL busy_cap bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_drain();
        int n, bad;
        logic hit;
        logic [NUM_SIG-1:0] d;
        n = 6;
        for (int i = 0; i < n; i++) resp[i] = NUM_SIG'($urandom);
        clear_mon();
        launch(32'(n));
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge axi_clk);
            if (rd_cnt >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        nvec++; if (hit !== 1'b1) begin nerr++; $display("FAIL rst_drain_reached got=%b exp=1", hit); end
        #1;
        axi_reset = 1'b1;
        @(posedge axi_clk); #1;
        nvec++; if ({busy, done, cfg_err, gen_if.write_channel_wrStrobe, gen_if.run, gen_if.read_channel_rdStrobe} !== 6'b0) begin nerr++; $display("FAIL rst_drain_ctrl got=%b exp=000000", {busy, done, cfg_err, gen_if.write_channel_wrStrobe, gen_if.run, gen_if.read_channel_rdStrobe}); end
        nvec++; if (gen_if.n_samples !== 32'd0 || gen_if.write_channel !== '0 || cap_rd_data !== '0) begin nerr++; $display("FAIL rst_drain_data n_samples=%0d wc=%0d cap=%0d exp=0,0,0", gen_if.n_samples, gen_if.write_channel, cap_rd_data); end
        axi_reset = 1'b0;
        repeat (5) @(posedge axi_clk);
        #1;
        nvec++; if (gen_if.read_channel_rdStrobe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_drain_quiet rd=%b busy=%b exp=0,0", gen_if.read_channel_rdStrobe, busy); end
        for (int i = 0; i < n; i++) resp[i] = NUM_SIG'($urandom);
        clear_mon();
        launch(32'(n));
        wait_done(5000);
        nvec++; if (tmo !== 1'b0 || wr_cnt !== n || rd_cnt !== n || done_err !== 1'b0) begin nerr++; $display("FAIL rst_rerun tmo=%b wr=%0d rd=%0d err=%b exp=0,%0d,%0d,0", tmo, wr_cnt, rd_cnt, done_err, n, n); end
        commit(n);
        bad = 0;
        for (int i = 0; i < n + 2; i++) begin
            cap_read(i, d);
            if (d !== cap_model[i]) bad++;
        end
        nvec++; if (bad !== 0) begin nerr++; $display("FAIL rst_rerun_cap bad_entries=%0d exp=0", bad); end
    endtask

    task automatic test_wait_len();
        int n;
        n = 6;
        clear_mon();
        launch(32'(n));
        wait_done(5000);
        nvec++; if (tmo !== 1'b0) begin nerr++; $display("FAIL wait_timeout got=%b exp=0", tmo); end
        nvec++; if (rd_first - run_cyc - 1 !== exp_wait(n)) begin nerr++; $display("FAIL wait_len got=%0d exp=%0d", rd_first - run_cyc - 1, exp_wait(n)); end
        nvec++; if (rd_last - rd_first + 1 !== n) begin nerr++; $display("FAIL wait_drain_span got=%0d exp=%0d", rd_last - rd_first + 1, n); end
        commit(n);
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_ramp();
        test_back_to_back();
        test_random();
        test_busy_ignore();
        test_reset_mid_drain();
        test_wait_len();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
